// File: rtl/serial_tx_reg.sv
// Framed serial transmitter: start bit, LSB-first data, optional parity, stop bit.
// Accepts a parallel word on a valid/ready handshake. Each bit is held CLKS_PER_BIT clocks.
module serial_tx_reg #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] st_data_input,
    input  logic              st_load,
    output logic              st_ready,
    output logic              st_busy,
    output logic              st_serial_out,
    output logic              st_done
);

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [DATA_W-1:0] shift;
    logic [DIV_W-1:0]  div;
    logic [BIT_W-1:0]  bit_cnt;
    logic              parity;
    logic              bit_end;

    assign bit_end = (div == DIV_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            shift         <= '0;
            div           <= '0;
            bit_cnt       <= '0;
            parity        <= 1'b0;
            st_ready      <= 1'b1;
            st_busy       <= 1'b0;
            st_serial_out <= 1'b1;
            st_done       <= 1'b0;
        end else begin
            st_done <= 1'b0;
            if (state != IDLE)
                div <= bit_end ? '0 : div + 1'b1;
            unique case (state)
                IDLE: begin
                    if (st_load) begin
                        shift         <= st_data_input;
                        parity        <= (^st_data_input) ^ (PARITY_ODD != 0);
                        div           <= '0;
                        bit_cnt       <= '0;
                        state         <= START;
                        st_serial_out <= 1'b0;
                        st_ready      <= 1'b0;
                        st_busy       <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state         <= DATA;
                        st_serial_out <= shift[0];
                        shift         <= shift >> 1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == BIT_MAX) begin
                            if (PARITY_EN != 0) begin
                                state         <= PARITY;
                                st_serial_out <= parity;
                            end else begin
                                state         <= STOP;
                                st_serial_out <= 1'b1;
                            end
                        end else begin
                            bit_cnt       <= bit_cnt + 1'b1;
                            st_serial_out <= shift[0];
                            shift         <= shift >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state         <= STOP;
                        st_serial_out <= 1'b1;
                    end
                end
                STOP: begin
                    // Ready rises together with done so a new word can follow immediately
                    if (bit_end) begin
                        state    <= IDLE;
                        st_ready <= 1'b1;
                        st_busy  <= 1'b0;
                        st_done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_reg.sv
// Bench for serial_tx_reg: four parameter variants checked every cycle
// against a frame-position model, plus directed literal checks.
module tb_serial_tx_reg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] load = '0;
    logic [3:0] din [4];
    logic [3:0] line, ready, busy, done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function automatic int cpb(input int i);
        return (i == 3) ? 1 : 4;
    endfunction

    function automatic logic pen(input int i);
        return (i == 2) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic podd(input int i);
        return (i == 1) ? 1'b1 : 1'b0;
    endfunction

    function automatic int flen(input int i);
        return (2 + 4 + int'(pen(i))) * cpb(i);
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int C = (g == 3) ? 1 : 4;
        localparam int P = (g == 2) ? 0 : 1;
        localparam int O = (g == 1) ? 1 : 0;
        serial_tx_reg #(
            .DATA_W(4), .CLKS_PER_BIT(C), .PARITY_EN(P), .PARITY_ODD(O)
        ) u_dut (
            .clk(clk),
            .reset(rst_n),
            .st_data_input(din[g]),
            .st_load(load[g]),
            .st_ready(ready[g]),
            .st_busy(busy[g]),
            .st_serial_out(line[g]),
            .st_done(done[g])
        );
    end

    // Model: per instance, whether a frame is running, cycles since acceptance, word
    logic       mbusy [4];
    logic       mdone [4];
    int         mcnt  [4];
    logic [3:0] mword [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mbusy[i] <= 1'b0;
                mdone[i] <= 1'b0;
                mcnt[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                mdone[i] <= 1'b0;
                if (mbusy[i]) begin
                    mcnt[i] <= mcnt[i] + 1;
                    if (mcnt[i] + 1 == flen(i)) begin
                        mbusy[i] <= 1'b0;
                        mdone[i] <= 1'b1;
                    end
                end else if (load[i]) begin
                    mbusy[i] <= 1'b1;
                    mcnt[i]  <= 0;
                    mword[i] <= din[i];
                end
            end
        end
    end

    function automatic logic exp_line(input int i);
        int b;
        if (!mbusy[i]) return 1'b1;
        b = mcnt[i] / cpb(i);
        if (b == 0) return 1'b0;
        if (b <= 4) return mword[i][b-1];
        if (pen(i) && b == 5) return (^mword[i]) ^ podd(i);
        return 1'b1;
    endfunction

    logic [3:0] ce, ca;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            ce = {exp_line(i), !mbusy[i], mbusy[i], mdone[i]};
            ca = {line[i], ready[i], busy[i], done[i]};
            total++;
            if (ca !== ce) begin
                bad++;
                $display("FAIL cycle inst%0d t=%0t line/ready/busy/done got %b want %b",
                         i, $time, ca, ce);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Send one word; bits[b] is the line sampled at the start of bit b
    task automatic run_frame(input int i, input logic [3:0] d,
                             output int lat, output logic [7:0] bits);
        int c;
        c = cpb(i);
        bits = '1;
        lat = -1;
        @(negedge clk);
        load[i] = 1'b1;
        din[i]  = d;
        @(posedge clk);
        #1;
        load[i] = 1'b0;
        din[i]  = 4'($urandom);
        bits[0] = line[i];
        for (int m = 1; m <= 200; m++) begin
            @(posedge clk);
            #1;
            if (m % c == 0 && m / c < 8) bits[m/c] = line[i];
            if (done[i]) begin
                lat = m;
                break;
            end
        end
    endtask

    int         lat;
    int         nd;
    logic [7:0] bits;

    initial begin
        for (int i = 0; i < 4; i++) din[i] = '0;
        #2 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                load[i] = 1'($urandom);
                din[i]  = 4'($urandom);
            end
        end
        #1;
        chk("rst_idle", {28'd0, line[0], ready[0], busy[0], done[0]}, 32'b1100);
        @(posedge clk);
        #1;
        load  = '0;
        rst_n = 1'b1;

        run_frame(0, 4'b1011, lat, bits);
        chk("f1011_bits", 32'(bits), 32'b1111_0110);
        chk("f1011_lat", 32'(lat), 32'd28);
        chk("f1011_ready", 32'(ready[0]), 32'd1);

        run_frame(1, 4'b0000, lat, bits);
        chk("odd_bits", 32'(bits), 32'b1110_0000);
        chk("odd_lat", 32'(lat), 32'd28);

        run_frame(2, 4'b0000, lat, bits);
        chk("nopar_bits", 32'(bits), 32'b1110_0000);
        chk("nopar_lat", 32'(lat), 32'd24);

        run_frame(3, 4'b1011, lat, bits);
        chk("cpb1_bits", 32'(bits), 32'b1111_0110);
        chk("cpb1_lat", 32'(lat), 32'd7);

        // Busy rejection: loads of 4'hC at cycles 5 and 20 must be ignored
        @(negedge clk);
        load[0] = 1'b1;
        din[0]  = 4'h3;
        @(posedge clk);
        #1;
        load[0] = 1'b0;
        nd = 0;
        lat = -1;
        bits = '1;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (k % 4 == 0 && k <= 24) bits[k/4] = line[0];
            load[0] = (k == 5 || k == 20);
            din[0]  = (k == 5 || k == 20) ? 4'hC : 4'($urandom);
            if (done[0]) begin
                nd++;
                lat = k;
            end
        end
        load[0] = 1'b0;
        chk("busy_bits", 32'(bits[6:1]), 32'b100011);
        chk("busy_ndone", 32'(nd), 32'd1);
        chk("busy_lat", 32'(lat), 32'd28);

        // Back-to-back: load held high, 4'h0 presented in the done cycle
        @(negedge clk);
        load[0] = 1'b1;
        din[0]  = 4'hF;
        @(posedge clk);
        #1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 20) chk("b2b_par1", 32'(line[0]), 32'd0);
            if (done[0]) begin
                lat = k;
                break;
            end
        end
        chk("b2b_done1", 32'(lat), 32'd28);
        din[0] = 4'h0;
        @(posedge clk);
        #1;
        chk("b2b_start2", {30'd0, line[0], busy[0]}, 32'b01);
        load[0] = 1'b0;
        lat = -1;
        for (int k = 30; k <= 90; k++) begin
            @(posedge clk);
            #1;
            if (k == 49) chk("b2b_par2", 32'(line[0]), 32'd0);
            if (done[0]) begin
                lat = k;
                break;
            end
        end
        chk("b2b_done2", 32'(lat), 32'd57);

        // Abort mid-frame with an asynchronous reset
        @(negedge clk);
        load[0] = 1'b1;
        din[0]  = 4'h9;
        @(posedge clk);
        #1;
        load[0] = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_async", {28'd0, line[0], ready[0], busy[0], done[0]}, 32'b1100);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done[0]) nd++;
        end
        chk("abort_nodone", 32'(nd), 32'd0);

        run_frame(0, 4'h5, lat, bits);
        chk("after_abort_bits", 32'(bits), 32'b1100_1010);
        chk("after_abort_lat", 32'(lat), 32'd28);

        // Random traffic on all variants
        repeat (800) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                load[i] = ($urandom % 4) == 0;
                din[i]  = 4'($urandom);
            end
        end
        @(negedge clk);
        load = '0;
        repeat (60) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
